fs4_iq_mixer: RTL and testbench
===============================

# fs4_iq_mixer

- Parallel-lane fs/4 quadrature downconverter with integrate-and-dump.
- Each beat carries UNR consecutive ADC samples. Every sample is multiplied by the fs/4 cosine pattern {+1,0,−1,0} to form I and by the sine pattern {0,+1,0,−1} to form Q.
- Phase is tracked across beats, per-lane products are registered, and all lanes are summed into I/Q accumulators over a programmable number of beats.
- Sits between the ADC capture path and the demodulation/readout logic.

## Interface
- DWIDTH, 14, input sample width
- UNR, 4, lanes per beat (≥1)
- AWIDTH, 32, accumulator width (≥ DWIDTH+1+$clog2(UNR)+1)
- CNTW, 16, acc_len width
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- din  in  [DWIDTH-1:0] x UNR  samples; lane k is the k-th sample in time
- din_valid  in  1  beat qualifier
- din_signed  in  1  0 = unsigned (zero-extend), 1 = two's complement (sign-extend); static between syncs
- phase_init  in  2  starting quarter-phase applied at sync
- sync  in  1  restart phase and frame
- acc_len  in  CNTW  beats per dump; 0 is treated as 1
- mix_i, mix_q  out  [DWIDTH:0] x UNR  signed per-lane products
- mix_valid  out  1  products qualifier
- acc_i, acc_q  out  AWIDTH  signed frame sums
- acc_valid  out  1  one-cycle dump strobe

## Operation
- Extension: x = {1'b0,din} in unsigned mode, or the sign-extended din in signed mode. Result is DWIDTH+1 signed. Negation cannot overflow in either mode.
- Lane phase: p_k = (phase_q + k) mod 4.
- I coefficient: p=0 → +x, p=1 → 0, p=2 → −x, p=3 → 0.
- Q coefficient: p=0 → 0, p=1 → +x, p=2 → 0, p=3 → −x.
- phase_q advances by UNR mod 4 on each accepted beat and holds when din_valid=0.
- sync:
  - The beat in the same cycle (if valid) uses phase_init, and phase_q becomes phase_init+UNR.
  - Without a valid beat, phase_q becomes phase_init.
- Accumulation:
  - Lane sums of mix_i and mix_q are sign-extended to AWIDTH and added to running sums on each mix_valid.
  - A beat counter counts mix_valid beats. When it equals len_q−1: acc_i/acc_q ← running + lane sum, acc_valid=1, running sums and counter clear.
  - Accumulators wrap modulo 2^AWIDTH.
- len_q ← max(acc_len,1) whenever rst_n=0 or sync=1. Changes to acc_len at other times are ignored.
- sync at the accumulation stage:
  - Clears the running sums and the counter in the same cycle.
  - Drops the stage-2 beat in flight, even if it would have completed the frame; no acc_valid is issued for it.
  - mix outputs still update normally.
- Reset values: mix_i, mix_q, acc_i, acc_q = 0; mix_valid = acc_valid = 0; phase_q = 0; counter = 0; running sums = 0. Reset mid-frame discards all partial state.

## Timing
- Stage 1: din beat at cycle t → mix_*, mix_valid at t+1.
- Stage 2: last beat of a frame at t → acc_*, acc_valid at t+2.
- acc_* hold between dumps.
- Full throughput: one beat per cycle, no backpressure.
- Gaps in din_valid stall phase and counter with no loss.
- acc_len=1: acc_valid follows every beat by 2 cycles.

## Structure
- Package fs4_mix_pkg:
  - phase_t (logic [1:0])
  - coef_t enum {C_ZERO, C_POS, C_NEG}
  - functions cos_coef(phase_t) and sin_coef(phase_t)
- Sub-module fs4_lane_mix: combinational extend + coefficient select for one lane, producing I and Q. Instantiated UNR times via generate.
- Phase register, stage-1 registers, adder tree, counter and accumulators live in the top level.

## Test plan
- Reset: rst_n low 3 cycles with din_valid=1, din=0x1234 → all outputs 0, valid flags low throughout. First beat after release uses phase 0.
- Unsigned, phase_init=0, sync + one beat din={100,100,100,100} → next cycle mix_i={0x0064,0,0x7F9C,0}, mix_q={0,0x0064,0,0x7F9C}, mix_valid for 1 cycle.
- UNR=3 build, continuous beats after sync with phase_init=0:
  - beat0 lane phases 0,1,2; beat1 phases 3,0,1; beat2 phases 2,3,0.
  - A din_valid gap between beats leaves the sequence unchanged.
- Signed, acc_len=4, din={1000,500,−1000,−500} ×4 beats → acc_i=8000, acc_q=4000, acc_valid for exactly 1 cycle, 2 cycles after beat 4. A further 4 beats give the same values again (running sums cleared).
- Extremes, phase_init=2:
  - Unsigned 0x3FFF → mix_i[0]=0x4001 (−16383).
  - Signed 0x2000 → mix_i[0]=0x2000 (+8192).
  - acc_len=0 → dump after every beat.
- Sync mid-frame, acc_len=4: 3 beats of all-ones, then sync with a valid beat of 10s, then 3 more beats of 10s → no acc_valid before the sync-frame completes; acc_i equals the sum of the 4 new beats only. Repeat with rst_n pulsed instead of sync → no dump, clean restart.

Source files
------------

// File: rtl/fs4_mix_pkg.sv
// Shared types for the fs/4 mixer: quarter-phase index and the
// three-valued mixing coefficient, plus the cosine/sine lookups.
package fs4_mix_pkg;

  typedef logic [1:0] phase_t;

  typedef enum logic [1:0] {
    C_ZERO,
    C_POS,
    C_NEG
  } coef_t;

  function automatic coef_t cos_coef(input phase_t p);
    case (p)
      2'd0:    return C_POS;
      2'd2:    return C_NEG;
      default: return C_ZERO;
    endcase
  endfunction

  function automatic coef_t sin_coef(input phase_t p);
    case (p)
      2'd1:    return C_POS;
      2'd3:    return C_NEG;
      default: return C_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/fs4_iq_mixer_if.sv
// Sample-in / products-and-sums-out bundle for fs4_iq_mixer.
interface fs4_iq_mixer_if #(
  parameter int DWIDTH = 14,
  parameter int UNR    = 4,
  parameter int AWIDTH = 32,
  parameter int CNTW   = 16
);
  // din_valid qualifies a beat and there is no ready: every valid beat is
  // consumed. mix_valid and acc_valid are one-cycle qualifiers on the outputs.
  logic [UNR-1:0][DWIDTH-1:0] din;
  logic                       din_valid;
  logic                       din_signed;
  logic [1:0]                 phase_init;
  logic                       sync;
  logic [CNTW-1:0]            acc_len;
  logic [UNR-1:0][DWIDTH:0]   mix_i;
  logic [UNR-1:0][DWIDTH:0]   mix_q;
  logic                       mix_valid;
  logic [AWIDTH-1:0]          acc_i;
  logic [AWIDTH-1:0]          acc_q;
  logic                       acc_valid;

  modport master (
    output din, din_valid, din_signed, phase_init, sync, acc_len,
    input  mix_i, mix_q, mix_valid, acc_i, acc_q, acc_valid
  );

  modport slave (
    input  din, din_valid, din_signed, phase_init, sync, acc_len,
    output mix_i, mix_q, mix_valid, acc_i, acc_q, acc_valid
  );
endinterface

// File: rtl/fs4_lane_mix.sv
// One lane of the fs/4 mixer: extend the raw sample to DWIDTH+1 signed and
// apply the cosine/sine coefficient for this lane's quarter-phase.
module fs4_lane_mix
  import fs4_mix_pkg::*;
#(
  parameter int DWIDTH = 14
) (
  input  logic [DWIDTH-1:0]        din,
  input  logic                     din_signed,
  input  phase_t                   phase,
  output logic signed [DWIDTH:0]   mix_i,
  output logic signed [DWIDTH:0]   mix_q
);

  logic signed [DWIDTH:0] x;

  // One extra bit means negation cannot overflow in either extension mode.
  always_comb begin
    x = din_signed ? $signed({din[DWIDTH-1], din}) : $signed({1'b0, din});
    case (cos_coef(phase))
      C_POS:   mix_i = x;
      C_NEG:   mix_i = -x;
      default: mix_i = '0;
    endcase
    case (sin_coef(phase))
      C_POS:   mix_q = x;
      C_NEG:   mix_q = -x;
      default: mix_q = '0;
    endcase
  end

endmodule

// File: rtl/fs4_iq_mixer.sv
// Parallel-lane fs/4 I/Q downconverter: phase tracking, registered per-lane
// products, then lane-sum integrate-and-dump over len_q beats.
module fs4_iq_mixer
  import fs4_mix_pkg::*;
#(
  parameter int DWIDTH = 14,
  parameter int UNR    = 4,
  parameter int AWIDTH = 32,
  parameter int CNTW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  fs4_iq_mixer_if.slave bus
);

  localparam phase_t UNR_STEP = phase_t'(UNR % 4);

  phase_t                     phase_q, phase_d, phase_cur;
  phase_t                     lane_phase [UNR];
  logic [UNR-1:0][DWIDTH:0]   lane_i, lane_q;
  logic [UNR-1:0][DWIDTH:0]   mix_i_q, mix_i_d, mix_q_q, mix_q_d;
  logic                       mix_valid_q, mix_valid_d;
  logic [CNTW-1:0]            len_q, len_d, len_sel;
  logic [CNTW-1:0]            cnt_q, cnt_d;
  logic signed [AWIDTH-1:0]   run_i_q, run_i_d, run_q_q, run_q_d;
  logic signed [AWIDTH-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic                       acc_valid_q, acc_valid_d;
  logic signed [AWIDTH-1:0]   sum_i, sum_q;
  logic signed [DWIDTH:0]     term_i, term_q;

  for (genvar k = 0; k < UNR; k++) begin : g_lane
    fs4_lane_mix #(.DWIDTH(DWIDTH)) u_lane (
      .din        (bus.din[k]),
      .din_signed (bus.din_signed),
      .phase      (lane_phase[k]),
      .mix_i      (lane_i[k]),
      .mix_q      (lane_q[k])
    );
  end

  // A sync beat is mixed with phase_init rather than the tracked phase.
  always_comb begin
    phase_cur = bus.sync ? phase_t'(bus.phase_init) : phase_q;
    for (int k = 0; k < UNR; k++) begin
      lane_phase[k] = phase_cur + phase_t'(k % 4);
    end
    phase_d = bus.sync ? phase_t'(bus.phase_init) : phase_q;
    if (bus.din_valid) phase_d = phase_cur + UNR_STEP;

    mix_valid_d = bus.din_valid;
    mix_i_d     = bus.din_valid ? lane_i : mix_i_q;
    mix_q_d     = bus.din_valid ? lane_q : mix_q_q;
  end

  always_comb begin
    sum_i  = '0;
    sum_q  = '0;
    term_i = '0;
    term_q = '0;
    for (int k = 0; k < UNR; k++) begin
      term_i = mix_i_q[k];
      term_q = mix_q_q[k];
      sum_i  = sum_i + term_i;
      sum_q  = sum_q + term_q;
    end
  end

  // Sync abandons the frame, including the beat currently in stage 2.
  always_comb begin
    len_sel     = (bus.acc_len == '0) ? CNTW'(1) : bus.acc_len;
    len_d       = bus.sync ? len_sel : len_q;
    cnt_d       = cnt_q;
    run_i_d     = run_i_q;
    run_q_d     = run_q_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    acc_valid_d = 1'b0;
    if (bus.sync) begin
      cnt_d   = '0;
      run_i_d = '0;
      run_q_d = '0;
    end else if (mix_valid_q) begin
      if (cnt_q == len_q - CNTW'(1)) begin
        acc_i_d     = run_i_q + sum_i;
        acc_q_d     = run_q_q + sum_q;
        acc_valid_d = 1'b1;
        cnt_d       = '0;
        run_i_d     = '0;
        run_q_d     = '0;
      end else begin
        cnt_d   = cnt_q + CNTW'(1);
        run_i_d = run_i_q + sum_i;
        run_q_d = run_q_q + sum_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= '0;
      mix_i_q     <= '0;
      mix_q_q     <= '0;
      mix_valid_q <= 1'b0;
      len_q       <= len_sel;
      cnt_q       <= '0;
      run_i_q     <= '0;
      run_q_q     <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      mix_i_q     <= mix_i_d;
      mix_q_q     <= mix_q_d;
      mix_valid_q <= mix_valid_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      run_i_q     <= run_i_d;
      run_q_q     <= run_q_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign bus.mix_i     = mix_i_q;
  assign bus.mix_q     = mix_q_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.acc_i     = acc_i_q;
  assign bus.acc_q     = acc_q_q;
  assign bus.acc_valid = acc_valid_q;

endmodule

// File: tb/tb_fs4_iq_mixer.sv
// Directed bench for fs4_iq_mixer: a UNR=4 instance for most scenarios and
// a UNR=3 instance for cross-beat phase tracking.
module tb_fs4_iq_mixer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fs4_iq_mixer_if #(.DWIDTH(14), .UNR(4), .AWIDTH(32), .CNTW(16)) bus ();
  fs4_iq_mixer_if #(.DWIDTH(14), .UNR(3), .AWIDTH(32), .CNTW(16)) bus3 ();

  fs4_iq_mixer #(.DWIDTH(14), .UNR(4), .AWIDTH(32), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fs4_iq_mixer #(.DWIDTH(14), .UNR(3), .AWIDTH(32), .CNTW(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [3:0][13:0] pack4(input logic [13:0] a, b, c, d);
    logic [3:0][13:0] v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0][13:0] d, input logic v, input logic s);
    bus.din       = d;
    bus.din_valid = v;
    bus.sync      = s;
  endtask

  task automatic test_reset();
    logic [3:0][14:0] ei, eq;
    rst_n = 1'b0;
    bus.din_signed = 1'b0; bus.phase_init = 2'd0; bus.acc_len = 16'd1;
    drive(pack4(14'h1234, 14'h1234, 14'h1234, 14'h1234), 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus.mix_valid !== 1'b0 || bus.acc_valid !== 1'b0 || bus.mix_i !== '0 ||
          bus.mix_q !== '0 || bus.acc_i !== '0 || bus.acc_q !== '0) begin
        bad++;
        $display("FAIL reset_outputs c%0d: mv=%b av=%b mix_i=%h acc_i=%h, want all zero",
                 c, bus.mix_valid, bus.acc_valid, bus.mix_i, bus.acc_i);
      end
    end
    rst_n = 1'b1;
    tick();
    ei = '0; eq = '0;
    ei[0] = 15'h1234; ei[2] = 15'h6DCC;
    eq[1] = 15'h1234; eq[3] = 15'h6DCC;
    total++;
    if (bus.mix_valid !== 1'b1 || bus.mix_i !== ei || bus.mix_q !== eq) begin
      bad++;
      $display("FAIL reset_first_beat: mv=%b mix_i=%h mix_q=%h, want 1 %h %h",
               bus.mix_valid, bus.mix_i, bus.mix_q, ei, eq);
    end
    drive('0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_unsigned();
    logic [3:0][14:0] ei, eq;
    bus.din_signed = 1'b0; bus.phase_init = 2'd0; bus.acc_len = 16'd1;
    drive(pack4(14'd100, 14'd100, 14'd100, 14'd100), 1'b1, 1'b1);
    tick();
    ei = '0; eq = '0;
    ei[0] = 15'h0064; ei[2] = 15'h7F9C;
    eq[1] = 15'h0064; eq[3] = 15'h7F9C;
    total++;
    if (bus.mix_valid !== 1'b1 || bus.mix_i !== ei || bus.mix_q !== eq) begin
      bad++;
      $display("FAIL unsigned_mix: mv=%b mix_i=%h mix_q=%h, want 1 %h %h",
               bus.mix_valid, bus.mix_i, bus.mix_q, ei, eq);
    end
    drive('0, 1'b0, 1'b0);
    tick();
    total++;
    if (bus.mix_valid !== 1'b0 || bus.acc_valid !== 1'b1 || bus.acc_i !== 32'd0) begin
      bad++;
      $display("FAIL unsigned_after: mv=%b av=%b acc_i=%h, want mv=0 av=1 acc_i=0",
               bus.mix_valid, bus.acc_valid, bus.acc_i);
    end
    tick();
    total++;
    if (bus.acc_valid !== 1'b0) begin
      bad++;
      $display("FAIL unsigned_strobe_len: acc_valid=%b, want 0", bus.acc_valid);
    end
    repeat (2) tick();
  endtask

  task automatic test_phase_unr3();
    logic [2:0][14:0] ei, eq;
    bus3.din_signed = 1'b0; bus3.phase_init = 2'd0; bus3.acc_len = 16'd3;
    bus3.din[0] = 14'd10; bus3.din[1] = 14'd20; bus3.din[2] = 14'd30;
    bus3.din_valid = 1'b1; bus3.sync = 1'b1;
    tick();
    ei[0] = 15'd10; ei[1] = 15'd0;   ei[2] = 15'(-30);
    eq[0] = 15'd0;  eq[1] = 15'd20;  eq[2] = 15'd0;
    total++;
    if (bus3.mix_i !== ei || bus3.mix_q !== eq) begin
      bad++;
      $display("FAIL unr3_beat0: mix_i=%h mix_q=%h, want %h %h", bus3.mix_i, bus3.mix_q, ei, eq);
    end
    bus3.din[0] = 14'd40; bus3.din[1] = 14'd50; bus3.din[2] = 14'd60;
    bus3.sync = 1'b0;
    tick();
    ei[0] = 15'd0;     ei[1] = 15'd50; ei[2] = 15'd0;
    eq[0] = 15'(-40);  eq[1] = 15'd0;  eq[2] = 15'd60;
    total++;
    if (bus3.mix_i !== ei || bus3.mix_q !== eq || bus3.acc_valid !== 1'b0) begin
      bad++;
      $display("FAIL unr3_beat1: mix_i=%h mix_q=%h av=%b, want %h %h 0",
               bus3.mix_i, bus3.mix_q, bus3.acc_valid, ei, eq);
    end
    bus3.din_valid = 1'b0;
    tick();
    total++;
    if (bus3.mix_valid !== 1'b0 || bus3.acc_valid !== 1'b0) begin
      bad++;
      $display("FAIL unr3_gap: mv=%b av=%b, want 0 0", bus3.mix_valid, bus3.acc_valid);
    end
    bus3.din[0] = 14'd70; bus3.din[1] = 14'd80; bus3.din[2] = 14'd90;
    bus3.din_valid = 1'b1;
    tick();
    ei[0] = 15'(-70); ei[1] = 15'd0;     ei[2] = 15'd90;
    eq[0] = 15'd0;    eq[1] = 15'(-80);  eq[2] = 15'd0;
    total++;
    if (bus3.mix_i !== ei || bus3.mix_q !== eq) begin
      bad++;
      $display("FAIL unr3_beat2: mix_i=%h mix_q=%h, want %h %h", bus3.mix_i, bus3.mix_q, ei, eq);
    end
    bus3.din_valid = 1'b0;
    tick();
    total++;
    if (bus3.acc_valid !== 1'b1 || bus3.acc_i !== 32'd50 || bus3.acc_q !== 32'(-40)) begin
      bad++;
      $display("FAIL unr3_dump: av=%b acc_i=%0d acc_q=%0d, want 1 50 -40",
               bus3.acc_valid, $signed(bus3.acc_i), $signed(bus3.acc_q));
    end
    repeat (2) tick();
  endtask

  task automatic test_signed_acc();
    bus.din_signed = 1'b1; bus.phase_init = 2'd0; bus.acc_len = 16'd4;
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 4; b++) begin
        drive(pack4(14'd1000, 14'd500, 14'(-1000), 14'(-500)), 1'b1, (f == 0 && b == 0));
        tick();
        total++;
        if (bus.acc_valid !== 1'b0) begin
          bad++;
          $display("FAIL signed_early f%0d b%0d: acc_valid=%b, want 0", f, b, bus.acc_valid);
        end
      end
      drive('0, 1'b0, 1'b0);
      tick();
      total++;
      if (bus.acc_valid !== 1'b1 || bus.acc_i !== 32'd8000 || bus.acc_q !== 32'd4000) begin
        bad++;
        $display("FAIL signed_dump f%0d: av=%b acc_i=%0d acc_q=%0d, want 1 8000 4000",
                 f, bus.acc_valid, $signed(bus.acc_i), $signed(bus.acc_q));
      end
      tick();
      total++;
      if (bus.acc_valid !== 1'b0 || bus.acc_i !== 32'd8000) begin
        bad++;
        $display("FAIL signed_hold f%0d: av=%b acc_i=%0d, want 0 8000",
                 f, bus.acc_valid, $signed(bus.acc_i));
      end
    end
  endtask

  task automatic test_extremes();
    bus.din_signed = 1'b0; bus.phase_init = 2'd2; bus.acc_len = 16'd0;
    drive(pack4(14'h3FFF, 14'd0, 14'd0, 14'd0), 1'b1, 1'b1);
    tick();
    total++;
    if (bus.mix_i[0] !== 15'h4001) begin
      bad++;
      $display("FAIL ext_unsigned_neg: mix_i[0]=%h, want 4001", bus.mix_i[0]);
    end
    drive('0, 1'b0, 1'b0);
    tick();
    total++;
    if (bus.acc_valid !== 1'b1 || bus.acc_i !== 32'(-16383) || bus.acc_q !== 32'd0) begin
      bad++;
      $display("FAIL ext_len0_dump_a: av=%b acc_i=%0d acc_q=%0d, want 1 -16383 0",
               bus.acc_valid, $signed(bus.acc_i), $signed(bus.acc_q));
    end
    bus.din_signed = 1'b1;
    drive(pack4(14'h2000, 14'd0, 14'd0, 14'd0), 1'b1, 1'b1);
    tick();
    total++;
    if (bus.mix_i[0] !== 15'h2000) begin
      bad++;
      $display("FAIL ext_signed_neg: mix_i[0]=%h, want 2000", bus.mix_i[0]);
    end
    drive('0, 1'b0, 1'b0);
    tick();
    total++;
    if (bus.acc_valid !== 1'b1 || bus.acc_i !== 32'd8192) begin
      bad++;
      $display("FAIL ext_len0_dump_b: av=%b acc_i=%0d, want 1 8192", bus.acc_valid, $signed(bus.acc_i));
    end
    drive(pack4(14'h2000, 14'd0, 14'd0, 14'd0), 1'b1, 1'b0);
    tick();
    drive(pack4(14'h3000, 14'd0, 14'd0, 14'd0), 1'b1, 1'b0);
    tick();
    total++;
    if (bus.acc_valid !== 1'b1 || bus.acc_i !== 32'd8192) begin
      bad++;
      $display("FAIL ext_b2b_c: av=%b acc_i=%0d, want 1 8192", bus.acc_valid, $signed(bus.acc_i));
    end
    drive('0, 1'b0, 1'b0);
    tick();
    total++;
    if (bus.acc_valid !== 1'b1 || bus.acc_i !== 32'd4096) begin
      bad++;
      $display("FAIL ext_b2b_d: av=%b acc_i=%0d, want 1 4096", bus.acc_valid, $signed(bus.acc_i));
    end
    repeat (2) tick();
  endtask

  task automatic test_sync_midframe(input bit use_reset);
    bus.din_signed = 1'b0; bus.phase_init = 2'd0; bus.acc_len = 16'd4;
    for (int b = 0; b < 3; b++) begin
      drive(pack4(14'h3FFF, 14'h3FFF, 14'd0, 14'd0), 1'b1, (b == 0));
      tick();
      total++;
      if (bus.acc_valid !== 1'b0) begin
        bad++;
        $display("FAIL restart_old r%0d b%0d: acc_valid=%b, want 0", use_reset, b, bus.acc_valid);
      end
    end
    if (use_reset) begin
      rst_n = 1'b0;
      drive(pack4(14'h3FFF, 14'h3FFF, 14'd0, 14'd0), 1'b1, 1'b0);
      tick();
      rst_n = 1'b1;
    end
    for (int b = 0; b < 4; b++) begin
      drive(pack4(14'd10, 14'd10, 14'd0, 14'd0), 1'b1, (!use_reset && b == 0));
      tick();
      total++;
      if (bus.acc_valid !== 1'b0) begin
        bad++;
        $display("FAIL restart_new r%0d b%0d: acc_valid=%b, want 0", use_reset, b, bus.acc_valid);
      end
    end
    drive('0, 1'b0, 1'b0);
    tick();
    total++;
    if (bus.acc_valid !== 1'b1 || bus.acc_i !== 32'd40 || bus.acc_q !== 32'd40) begin
      bad++;
      $display("FAIL restart_dump r%0d: av=%b acc_i=%0d acc_q=%0d, want 1 40 40",
               use_reset, bus.acc_valid, $signed(bus.acc_i), $signed(bus.acc_q));
    end
    repeat (2) tick();
  endtask

  initial begin
    bus.din = '0; bus.din_valid = 1'b0; bus.din_signed = 1'b0;
    bus.phase_init = 2'd0; bus.sync = 1'b0; bus.acc_len = 16'd1;
    bus3.din = '0; bus3.din_valid = 1'b0; bus3.din_signed = 1'b0;
    bus3.phase_init = 2'd0; bus3.sync = 1'b0; bus3.acc_len = 16'd1;
    test_reset();
    test_unsigned();
    test_phase_unr3();
    test_signed_acc();
    test_extremes();
    test_sync_midframe(1'b0);
    test_sync_midframe(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
